// File: rtl/ehgu_fifo_pack.sv
// Packs RATIO narrow FIFO read words into one wide ready/valid word.
// The FIFO side cannot stall: words that arrive while a packed word is parked are dropped and flagged.
module ehgu_fifo_pack #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    localparam int CW = $clog2(RATIO + 1)
) (
    input  logic                     clk1,
    input  logic                     rrstn,
    input  logic                     din_valid,
    input  logic [WIDTH-1:0]         din,
    input  logic                     flush,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [WIDTH*RATIO-1:0]   dout,
    output logic [CW-1:0]            dout_cnt,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     o_dbg_state
);

    generate
        if (RATIO < 2) begin : g_ratio_check
            $error("ehgu_fifo_pack: RATIO must be >= 2");
        end
    endgenerate

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_idx;
    logic [CW-1:0]            r_acc_cnt;
    logic [WIDTH*RATIO-1:0]   r_acc;
    logic [WIDTH*RATIO-1:0]   r_dout;
    logic [CW-1:0]            r_dout_cnt;
    logic                     r_dout_valid;
    logic                     r_ovf;

    logic [WIDTH*RATIO-1:0]   w_acc_next;
    logic [CW-1:0]            w_cnt;
    logic                     w_free;
    logic                     w_full;
    logic                     w_flush_done;
    logic                     w_done;
    logic                     w_drop;

    // Incoming word lands in lane r_idx; lanes beyond it stay zero because the accumulator is cleared per group.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (din_valid && (r_idx == CW'(k))) begin
                w_acc_next[k*WIDTH +: WIDTH] = din;
            end
        end
    end

    assign w_free       = !r_dout_valid || dout_ready;
    assign w_full       = din_valid && (r_idx == CW'(RATIO - 1));
    assign w_flush_done = flush && (din_valid || (r_idx != '0));
    assign w_done       = (r_state == FILL) && (w_full || w_flush_done);
    assign w_cnt        = din_valid ? (r_idx + CW'(1)) : r_idx;
    assign w_drop       = (r_state == HOLD) && din_valid;

    always_ff @(posedge clk1 or negedge rrstn) begin
        if (!rrstn) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_acc_cnt    <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_cnt   <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end

            // Set wins over clear so a drop in the clear cycle is never lost.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                FILL: begin
                    if (w_done) begin
                        r_idx <= '0;
                        if (w_free) begin
                            r_dout       <= w_acc_next;
                            r_dout_cnt   <= w_cnt;
                            r_dout_valid <= 1'b1;
                            r_acc        <= '0;
                        end else begin
                            r_acc     <= w_acc_next;
                            r_acc_cnt <= w_cnt;
                            r_state   <= HOLD;
                        end
                    end else if (din_valid) begin
                        r_acc <= w_acc_next;
                        r_idx <= r_idx + CW'(1);
                    end
                end
                HOLD: begin
                    if (w_free) begin
                        r_dout       <= r_acc;
                        r_dout_cnt   <= r_acc_cnt;
                        r_dout_valid <= 1'b1;
                        r_acc        <= '0;
                        r_state      <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign dout_valid  = r_dout_valid;
    assign dout        = r_dout;
    assign dout_cnt    = r_dout_cnt;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: doc/ehgu_fifo_pack.md
Name: ehgu_fifo_pack

Overview:
- Read-side consumer of the team FIFO. Collects narrow words from the FIFO output stream (dout_valid/dout) into one wide word.
- Presents the wide word on a ready/valid interface for a wider downstream datapath.
- The FIFO read side cannot be stalled. Words arriving when the block has no room are dropped and flagged on a sticky overflow.
- Supports a flush to emit a partially filled word.

Parameters:
- WIDTH, 8, width of one input word.
- RATIO, 4, input words per output word; must be >= 2 (elaboration error otherwise).
- CW, $clog2(RATIO+1), width of dout_cnt (local, derived).

Ports:
- clk1  input  1  read-side clock; all logic on posedge.
- rrstn  input  1  asynchronous active-low reset.
- din_valid  input  1  input word valid; connects to FIFO dout_valid.
- din  input  WIDTH  input word; connects to FIFO dout.
- flush  input  1  emit the current partial word.
- dout_valid  output  1  wide word valid.
- dout_ready  input  1  downstream accepts the wide word.
- dout  output  WIDTH*RATIO  wide word.
- dout_cnt  output  CW  number of valid lanes in dout, 1..RATIO.
- overflow  output  1  sticky input-drop flag.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (async assert, sync-safe deassert on clk1):
  - dout_valid=0, dout=0, dout_cnt=0, overflow=0.
  - Lane index idx=0, accumulator=0, state=FILL.
- Lane order: the k-th word of a group goes to dout[k*WIDTH +: WIDTH]; first word is in the LSBs.
- Unused lanes of a partial word read as 0.
- Output register (OREG):
  - Holds dout/dout_cnt/dout_valid. Transfer occurs when dout_valid && dout_ready.
  - OREG is free this cycle if !dout_valid || dout_ready.
  - dout and dout_cnt stay stable while dout_valid && !dout_ready.
- State FILL:
  - On din_valid, write din into lane idx.
  - If idx < RATIO-1, then idx++.
  - If idx == RATIO-1, the word completes with cnt=RATIO.
  - flush with idx > 0 completes a partial word with cnt=idx; if din_valid is also high that cycle, din is included first, giving cnt=idx+1.
  - flush with idx=0 and no din_valid is a no-op.
  - If din_valid completes a full word and flush is high the same cycle, a single word with cnt=RATIO is emitted.
  - On completion with OREG free: OREG loads the next cycle (latency 1 clk1 from the last input word). idx=0, accumulator cleared, stay in FILL.
  - On completion with OREG not free: the accumulator holds the word with its cnt and the state moves to HOLD.
- State HOLD:
  - din_valid is dropped and sets overflow.
  - flush is ignored.
  - When OREG is free, the held word loads into OREG next cycle, idx=0, and the state returns to FILL.
  - din_valid in that same release cycle is still dropped and sets overflow.
- Throughput: one wide word per RATIO input cycles with dout_ready=1. Back-to-back completions never drop data while dout_ready=1.
- overflow: set-dominant. Set on any dropped din_valid, cleared by ovf_clr only when no drop occurs that cycle.
- Reset mid-operation: partial words and the held word are discarded; no output is produced for them after reset.

Test Plan:
- Reset check: hold rrstn=0 with random inputs -> dout_valid=0, dout=0, dout_cnt=0, overflow=0. After release, no output until new input arrives.
- Full pack (WIDTH=8, RATIO=4, dout_ready=1):
  - Stimulus: din 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Response: the cycle after 0x44, dout=0x44332211, dout_cnt=4, dout_valid=1 for exactly one cycle.
- Flush:
  - Case A: 0xA1, 0xA2, then flush alone -> dout=0x0000A2A1, cnt=2.
  - Case B: 0xB1, then flush with din=0xB2 in the same cycle -> dout=0x0000B2B1, cnt=2.
  - Case C: flush with idx=0 -> no output.
- Backpressure and overflow:
  - Stimulus: dout_ready=0, words 0x01..0x08, then 0x09.
  - Response: OREG=0x04030201 and 0x08070605 held in HOLD; 0x09 is dropped and overflow=1.
  - Then raise dout_ready=1 -> 0x04030201 then 0x08070605 on consecutive cycles, never 0x09. overflow stays 1 until ovf_clr.
- Overflow priority: in HOLD, pulse ovf_clr in the same cycle as a dropped din_valid -> overflow=1. Pulse ovf_clr alone -> overflow=0 next cycle.
- Reset mid-operation: send 0x55, 0x66, assert rrstn for one cycle, then send 0x01..0x04 -> only dout=0x04030201, cnt=4 is produced.
